mem_fetch_ctrl: RTL and testbench
=================================

MEM_FETCH_CTRL -- requirements
Module: mem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 1, giving extra cycles mem_readE is held before mem_data is sampled (range 0..15).
REQ-002 The block SHALL have parameter ADDR_STEP, default 1, giving the address increment per fetched word.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  burst request, sampled only in IDLE.
REQ-006 base_addr  in  27  first word address, captured on accepted start.
REQ-007 word_cnt  in  8  words to fetch, captured on accepted start; 0 = empty burst.
REQ-008 mem_addr  out  27  address to the downstream memory's address port.
REQ-009 mem_readE  out  1  read enable to the memory's readE port.
REQ-010 mem_data  in  32  read data from the memory.
REQ-011 out_data  out  32  fetched word, valid while out_valid=1.
REQ-012 out_valid  out  1 / out_ready  in  1  output handshake; transfer when both are 1 on a clk edge.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at burst end.
REQ-015 err  out  1  address-wrap error flag (exists only with MEM_FETCH_WRAPCHK_EN).

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, STALL, DRAIN, FIN.
REQ-017 In IDLE, start=1 with word_cnt>0 SHALL capture base_addr/word_cnt, set busy and enter ISSUE next cycle; word_cnt=0 SHALL go to FIN directly (no memory read).
REQ-018 In ISSUE, mem_addr SHALL hold the current address and mem_readE=1 for exactly READ_WAIT+1 cycles; mem_data SHALL be written to the output buffer on the clk edge ending the last of those cycles.
REQ-019 After a write, address SHALL advance by ADDR_STEP (modulo 2^27) and remaining count decrement; if remaining=0 go to DRAIN, else if buffer full go to STALL, else start the next ISSUE immediately.
REQ-020 In STALL, mem_readE SHALL be 0 and mem_addr hold; return to ISSUE the cycle after buffer has a free entry.
REQ-021 The output buffer SHALL be a 2-entry FIFO, in-order; out_data SHALL be the head entry; out_valid = not empty.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; a pop when empty or push when full SHALL never occur (FSM guards push).
REQ-023 ISSUE SHALL only be entered with at least one free FIFO entry, so a sampled word is never dropped.
REQ-024 DRAIN SHALL wait until the FIFO is empty, then enter FIN; FIN SHALL assert done for one cycle, clear busy and return to IDLE.
REQ-025 start while not in IDLE SHALL be ignored.
REQ-026 mem_readE SHALL be 0 in every state except ISSUE.

Reset
REQ-027 rst_n=0 SHALL immediately, regardless of clk, force IDLE, mem_addr=0, mem_readE=0, FIFO empty, out_valid=0, out_data=0, busy=0, done=0, err=0, counters 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no done pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-029 Macro MEM_FETCH_WRAPCHK_EN defined: if the address advance in REQ-019 wraps past 27'h7FFFFFF with words remaining, the block SHALL set err (sticky until next accepted start or reset), stop issuing, and go to DRAIN.
REQ-030 Macro undefined: the err port SHALL not exist and the address SHALL wrap silently to continue the burst.

Verification
REQ-031 Reset; base_addr=22, word_cnt=4, out_ready=1, READ_WAIT=1 -> mem_addr 22,23,24,25 each with mem_readE high 2 cycles; four words out in order; done pulse once; busy low after.
REQ-032 word_cnt=3, out_ready=0 -> two words buffered, STALL with mem_readE=0 at address 24; out_ready=1 -> third read issued, all three delivered, done.
REQ-033 word_cnt=0 -> no mem_readE pulse; done two cycles after start; out_valid stays 0.
REQ-034 Assert rst_n=0 mid-burst between clk edges -> outputs clear immediately; no done; new start base_addr=100, word_cnt=1 completes normally.
REQ-035 With MEM_FETCH_WRAPCHK_EN: base_addr=27'h7FFFFFE, word_cnt=4 -> two words delivered, err=1, done pulse; without macro -> four words from addresses 7FFFFFE,7FFFFFF,0,1.
REQ-036 start pulsed while busy -> ignored; burst length and addresses unchanged.

Source files
------------

// File: rtl/mem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_fetch_ctrl_if
//   Bundles every non-clock signal of mem_fetch_ctrl: the burst request,
//   the downstream memory read port, the output stream and the status flags.
//
//   Request    : start, base_addr[26:0], word_cnt[7:0]
//   Memory     : mem_addr[26:0], mem_readE, mem_data[31:0]
//   Stream     : out_data[31:0], out_valid, out_ready
//   Status     : busy, done, err (err only with MEM_FETCH_WRAPCHK_EN)
//
//   Handshake (out_valid/out_ready): a word transfers on every rising clk
//   edge where both are 1. out_valid never depends on out_ready, and
//   out_data is stable while out_valid=1 and out_ready=0.
//
//   Modports: master = the fetch controller, slave = its environment.
// ---------------------------------------------------------------------------
interface mem_fetch_ctrl_if;
    logic        start;
    logic [26:0] base_addr;
    logic [7:0]  word_cnt;
    logic [26:0] mem_addr;
    logic        mem_readE;
    logic [31:0] mem_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef MEM_FETCH_WRAPCHK_EN
    logic        err;
`endif

    modport master (
        input  start, base_addr, word_cnt, mem_data, out_ready,
        output mem_addr, mem_readE, out_data, out_valid, busy, done
`ifdef MEM_FETCH_WRAPCHK_EN
        , output err
`endif
    );

    modport slave (
        output start, base_addr, word_cnt, mem_data, out_ready,
        input  mem_addr, mem_readE, out_data, out_valid, busy, done
`ifdef MEM_FETCH_WRAPCHK_EN
        , input err
`endif
    );
endinterface

// File: rtl/mem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// mem_fetch_ctrl
//   Burst read controller. On an accepted start it reads word_cnt words
//   from a simple synchronous memory starting at base_addr, holding each
//   address with mem_readE=1 for READ_WAIT+1 cycles and sampling mem_data
//   on the edge that ends the last of them. Words go through a 2-entry FIFO
//   to a valid/ready output stream. The controller stalls when the FIFO is
//   full, drains it at the end of the burst and pulses done once.
//
//   Parameters : READ_WAIT (0..15) extra read-hold cycles,
//                ADDR_STEP address increment per word (modulo 2^27).
//   Ports      : clk, rst_n (async, active low),
//                bus (mem_fetch_ctrl_if.master), state_dbg (FSM state).
//   Option     : MEM_FETCH_WRAPCHK_EN -- when defined, an address advance
//                that wraps past 27'h7FFFFFF with words still remaining
//                sets the sticky err flag and ends the burst early.
//                Undefined: no err port, the address wraps silently.
// ---------------------------------------------------------------------------
module mem_fetch_ctrl #(
    parameter int READ_WAIT = 1,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_fetch_ctrl_if.master  bus,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        STALL = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [3:0]  WAIT_LAST = 4'(READ_WAIT);
    localparam logic [26:0] STEP      = 27'(ADDR_STEP);

    state_t      state;
    logic [26:0] addr;
    logic        read_en;
    logic [7:0]  remaining;
    logic [3:0]  wait_cnt;
    logic        busy_q;
    logic        done_q;

    logic [31:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;

    logic        last_wait;
    logic        push;
    logic        pop;
    logic [1:0]  cnt_after_push;
    logic [26:0] addr_next;

`ifdef MEM_FETCH_WRAPCHK_EN
    logic [27:0] addr_sum;
    logic        wrapped;
    logic        err_q;

    // The carry out of the 27-bit add is exactly the wrap condition.
    assign addr_sum  = {1'b0, addr} + {1'b0, STEP};
    assign addr_next = addr_sum[26:0];
    assign wrapped   = addr_sum[27];
    assign bus.err   = err_q;
`else
    assign addr_next = addr + STEP;
`endif

    assign last_wait = (wait_cnt == WAIT_LAST);
    assign push      = (state == ISSUE) && last_wait;
    assign pop       = bus.out_valid && bus.out_ready;
    // Occupancy after this edge's push, accounting for a simultaneous pop.
    assign cnt_after_push = pop ? fifo_cnt : fifo_cnt + 2'd1;

    // Burst FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            read_en   <= 1'b0;
            remaining <= '0;
            wait_cnt  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_FETCH_WRAPCHK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr      <= bus.base_addr;
                        remaining <= bus.word_cnt;
                        wait_cnt  <= '0;
                        busy_q    <= 1'b1;
`ifdef MEM_FETCH_WRAPCHK_EN
                        err_q     <= 1'b0;
`endif
                        if (bus.word_cnt != 8'd0) begin
                            state   <= ISSUE;
                            read_en <= 1'b1;
                        end else begin
                            state   <= FIN;
                        end
                    end
                end

                ISSUE: begin
                    if (last_wait) begin
                        // mem_data is pushed into the FIFO on this edge.
                        addr      <= addr_next;
                        remaining <= remaining - 8'd1;
                        wait_cnt  <= '0;
                        if (remaining == 8'd1) begin
                            state   <= DRAIN;
                            read_en <= 1'b0;
`ifdef MEM_FETCH_WRAPCHK_EN
                        end else if (wrapped) begin
                            err_q   <= 1'b1;
                            state   <= DRAIN;
                            read_en <= 1'b0;
`endif
                        end else if (cnt_after_push == 2'd2) begin
                            state   <= STALL;
                            read_en <= 1'b0;
                        end
                        // Otherwise stay in ISSUE with read_en held high.
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                STALL: begin
                    if (fifo_cnt != 2'd2) begin
                        state   <= ISSUE;
                        read_en <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (fifo_cnt == 2'd0) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    read_en <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO. The FSM only pushes when an entry is free,
    // and pop is qualified by out_valid, so no overflow/underflow guards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign bus.mem_addr  = addr;
    assign bus.mem_readE = read_en;
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_mem_fetch_ctrl;

    localparam int READ_WAIT = 1;
    localparam int ADDR_STEP = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    mem_fetch_ctrl_if bus();

    mem_fetch_ctrl #(.READ_WAIT(READ_WAIT), .ADDR_STEP(ADDR_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- memory model ----------------
    // Returns the real word only once the address has been held with readE
    // for READ_WAIT earlier cycles; before that it returns the inverse, so
    // an early sample shows up as a data miscompare.
    function automatic logic [31:0] mem_word(input logic [26:0] a);
        return {a, 5'b10110} ^ 32'h5A3C_96E1;
    endfunction

    logic [26:0] p_addr;
    logic        p_re;
    int          p_hold;
    int          hold_cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_addr <= '0;
            p_re   <= 1'b0;
            p_hold <= 0;
        end else begin
            p_addr <= bus.mem_addr;
            p_re   <= bus.mem_readE;
            p_hold <= hold_cur;
        end
    end

    always_comb begin
        hold_cur = 0;
        if (bus.mem_readE && p_re && (p_addr == bus.mem_addr)) hold_cur = p_hold + 1;
    end

    assign bus.mem_data = (bus.mem_readE && hold_cur >= READ_WAIT) ?
                          mem_word(bus.mem_addr) : ~mem_word(bus.mem_addr);

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [26:0] exp_addr_q[$];
    int          exp_done = 0;
    int          n_done = 0;
    bit          exp_err = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- out_ready driver ----------------
    bit rand_ready = 1'b0;
    bit ready_val  = 1'b1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // ---------------- monitors ----------------
    // Output stream: every transfer must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("out_extra_word", 32'(exp_q.size()), 32'd1);
            else check("out_data", bus.out_data, exp_q.pop_front());
        end
    end

    // Read runs: each readE run must be at the next expected address and
    // last exactly READ_WAIT+1 cycles.
    logic [26:0] run_addr;
    int          run_len = 0;
    bit          in_run = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_run = 1'b0;
        end else begin
            if (in_run && (!bus.mem_readE || bus.mem_addr != run_addr)) begin
                check("readE_len", 32'(run_len), 32'(READ_WAIT + 1));
                if (exp_addr_q.size() == 0) check("extra_read", 32'(exp_addr_q.size()), 32'd1);
                else check("read_addr", 32'(run_addr), 32'(exp_addr_q.pop_front()));
                in_run = 1'b0;
            end
            if (bus.mem_readE && !in_run) begin
                in_run   = 1'b1;
                run_addr = bus.mem_addr;
                run_len  = 1;
            end else if (bus.mem_readE) begin
                run_len++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.done) n_done++;
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1 while the DUT is idle. The model lists the words
    // a burst must deliver straight from base, count and step.
    task automatic issue_start(input logic [26:0] base, input logic [7:0] cnt);
        longint a;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.word_cnt  = cnt;
        exp_err = 1'b0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = longint'(base) + longint'(i) * ADDR_STEP;
`ifdef MEM_FETCH_WRAPCHK_EN
            if (a >= 64'h800_0000) begin
                exp_err = 1'b1;
                break;
            end
`endif
            exp_addr_q.push_back(27'(a));
            exp_q.push_back(mem_word(27'(a)));
        end
        exp_done++;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Waits for busy to drop; optionally throws ignored start pulses at
    // the DUT while it is busy.
    task automatic wait_idle(input bit junk);
        int k;
        k = 0;
        while (bus.busy && k < 4000) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                bus.start     = 1'b1;
                bus.base_addr = 27'($urandom);
                bus.word_cnt  = 8'($urandom_range(1, 20));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.start = 1'b0;
    endtask

    task automatic finish_burst(input bit junk);
        wait_idle(junk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_after_burst", 32'(bus.busy), 32'd0);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("reads_left", 32'(exp_addr_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(exp_done));
        check("out_valid_idle", 32'(bus.out_valid), 32'd0);
`ifdef MEM_FETCH_WRAPCHK_EN
        check("err_flag", 32'(bus.err), 32'(exp_err));
`endif
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.word_cnt  = '0;

        // Reset state
        #12;
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_readE", 32'(bus.mem_readE), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
`ifdef MEM_FETCH_WRAPCHK_EN
        check("rst_err", 32'(bus.err), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 4-word burst, always ready
        ready_val = 1'b1;
        issue_start(27'd22, 8'd4);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        finish_burst(1'b0);

        // Back-pressure: two words buffered, stall at address 24
        ready_val = 1'b0;
        @(posedge clk); #1;
        issue_start(27'd22, 8'd3);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("stall_readE", 32'(bus.mem_readE), 32'd0);
        check("stall_addr", 32'(bus.mem_addr), 32'd24);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_head", bus.out_data, mem_word(27'd22));
        check("stall_busy", 32'(bus.busy), 32'd1);
        ready_val = 1'b1;
        finish_burst(1'b0);

        // Empty burst: done two cycles after start, no read, no output
        issue_start(27'd300, 8'd0);
        check("empty_done_early", 32'(bus.done), 32'd0);
        check("empty_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("empty_done", 32'(bus.done), 32'd1);
        check("empty_out_valid", 32'(bus.out_valid), 32'd0);
        finish_burst(1'b0);

        // Start pulses while busy are ignored
        issue_start(27'd1000, 8'd6);
        finish_burst(1'b1);

        // Asynchronous reset mid-burst, between clock edges
        issue_start(27'd50, 8'd5);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_readE", 32'(bus.mem_readE), 32'd0);
        check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_data", bus.out_data, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        exp_q.delete();
        exp_addr_q.delete();
        exp_done--;
        rst_n = 1'b1;
        check("arst_no_done", 32'(n_done), 32'(exp_done));
        @(posedge clk); #1;
        issue_start(27'd100, 8'd1);
        finish_burst(1'b0);

        // Address wrap at the top of the space
        issue_start(27'h7FFFFFE, 8'd4);
        finish_burst(1'b0);

        // Randomized bursts with random back-pressure and ignored starts
        rand_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            logic [26:0] base;
            if ($urandom_range(0, 3) == 0) base = 27'h7FFFFFF - 27'($urandom_range(0, 4));
            else base = 27'($urandom);
            issue_start(base, 8'($urandom_range(0, 9)));
            finish_burst(1'b1);
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
